// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, address width, FSM state encoding and
// the background palette index used by the display path.
package fb_pkg;
  localparam int unsigned FB_WIDTH  = 640;
  localparam int unsigned FB_HEIGHT = 480;
  localparam int unsigned FB_ADDR_W = 20;
  localparam logic [7:0]  BG_COLOR  = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } fb_state_e;
endpackage

// File: rtl/fb_addr_gen.sv
// Rectangle walker: col/row counters, row_base accumulator and clip test.
// The only multiply happens at load time; per-pixel stepping is adds only.
module fb_addr_gen #(
  parameter int unsigned FB_WIDTH  = fb_pkg::FB_WIDTH,
  parameter int unsigned FB_HEIGHT = fb_pkg::FB_HEIGHT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         load_i,
  input  logic                         step_i,
  input  logic [10:0]                  xpos_i,
  input  logic [10:0]                  ypos_i,
  input  logic [10:0]                  width_i,
  input  logic [10:0]                  height_i,
  output logic [fb_pkg::FB_ADDR_W-1:0] addr_o,
  output logic                         in_bounds_o,
  output logic                         last_o
);
  localparam int unsigned AW = fb_pkg::FB_ADDR_W;
  localparam logic [11:0] W12 = 12'(FB_WIDTH);
  localparam logic [11:0] H12 = 12'(FB_HEIGHT);

  logic [10:0]   xpos_q, ypos_q, width_q, height_q;
  logic [10:0]   xpos_d, ypos_d, width_d, height_d;
  logic [10:0]   col_q, row_q, col_d, row_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [11:0]   x, y;
  logic          col_end;

  always_comb begin
    x           = {1'b0, xpos_q} + {1'b0, col_q};
    y           = {1'b0, ypos_q} + {1'b0, row_q};
    col_end     = (col_q == width_q - 11'd1);
    last_o      = col_end && (row_q == height_q - 11'd1);
    in_bounds_o = (x < W12) && (y < H12);
    addr_o      = row_base_q + AW'(xpos_q) + AW'(col_q);
  end

  always_comb begin
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    width_d    = width_q;
    height_d   = height_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    if (load_i) begin
      xpos_d     = xpos_i;
      ypos_d     = ypos_i;
      width_d    = width_i;
      height_d   = height_i;
      col_d      = '0;
      row_d      = '0;
      row_base_d = AW'(ypos_i) * AW'(FB_WIDTH);
    end else if (step_i) begin
      if (col_end) begin
        col_d      = '0;
        row_d      = row_q + 11'd1;
        row_base_d = row_base_q + AW'(FB_WIDTH);
      end else begin
        col_d = col_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      xpos_q     <= '0;
      ypos_q     <= '0;
      width_q    <= '0;
      height_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
    end else begin
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      width_q    <= width_d;
      height_q   <= height_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
    end
  end
endmodule

// File: rtl/framebuffer_writer.sv
// Streams a row-major pixel rectangle into framebuffer RAM write cycles,
// dropping pixels that fall outside the visible area.
module framebuffer_writer #(
  parameter int unsigned FB_WIDTH  = fb_pkg::FB_WIDTH,
  parameter int unsigned FB_HEIGHT = fb_pkg::FB_HEIGHT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [10:0]                  xpos,
  input  logic [10:0]                  ypos,
  input  logic [10:0]                  width,
  input  logic [10:0]                  height,
  input  logic [7:0]                   pix_data,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_we,
  output logic [fb_pkg::FB_ADDR_W-1:0] mem_addr,
  output logic [7:0]                   mem_data
);
  import fb_pkg::fb_state_e;
  import fb_pkg::ST_IDLE;
  import fb_pkg::ST_WRITE;
  import fb_pkg::ST_DONE;

  localparam int unsigned AW = fb_pkg::FB_ADDR_W;

  fb_state_e     state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [AW-1:0] gen_addr;
  logic          gen_in_bounds, gen_last;
  logic          load, accept;

  assign pix_ready = (state_q == ST_WRITE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
  assign load      = (state_q == ST_IDLE) && start;
  assign accept    = pix_valid && pix_ready;

  fb_addr_gen #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT)
  ) u_addr_gen (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (load),
    .step_i      (accept),
    .xpos_i      (xpos),
    .ypos_i      (ypos),
    .width_i     (width),
    .height_i    (height),
    .addr_o      (gen_addr),
    .in_bounds_o (gen_in_bounds),
    .last_o      (gen_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (start)
          state_d = (width == '0 || height == '0) ? ST_DONE : ST_WRITE;
      ST_WRITE:
        if (accept && gen_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Address/data hold their last value between writes
  always_comb begin
    we_d   = accept && gen_in_bounds;
    addr_d = we_d ? gen_addr : addr_q;
    data_d = we_d ? pix_data : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer; expected writes are queued
// when pixels are driven and popped when mem_we appears.
module tb_framebuffer_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] xpos = '0, ypos = '0, width = '0, height = '0;
  logic [7:0]  pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready, busy, done, mem_we;
  logic [19:0] mem_addr;
  logic [7:0]  mem_data;

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } wr_t;

  wr_t q[$];
  int  n_assert = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  framebuffer_writer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .xpos      (xpos),
    .ypos      (ypos),
    .width     (width),
    .height    (height),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .busy      (busy),
    .done      (done),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest queued one
  always @(negedge clk) begin
    if (!rst && mem_we === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_write", {12'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", {12'd0, mem_addr}, e.addr);
        chk("wr_data", {24'd0, mem_data}, e.data);
      end
    end
  end

  task automatic cmd(input int x, input int y, input int w, input int h);
    xpos = 11'(x); ypos = 11'(y); width = 11'(w); height = 11'(h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pixel(input int x, input int y, input logic [7:0] d,
                       input bit is_last);
    bit inb;
    inb = (x < 640) && (y < 480);
    chk("ready_before_px", {31'd0, pix_ready}, 1);
    pix_valid = 1'b1;
    pix_data  = d;
    if (inb) q.push_back('{addr: y * 640 + x, data: d});
    @(posedge clk); #1;
    pix_valid = 1'b0;
    chk("we_after_px", {31'd0, mem_we}, {31'd0, inb});
    if (is_last) begin
      chk("done_last", {31'd0, done}, 1);
      chk("ready_last", {31'd0, pix_ready}, 0);
    end
  endtask

  task automatic stall_cycle();
    pix_valid = 1'b0;
    @(posedge clk); #1;
    chk("stall_we", {31'd0, mem_we}, 0);
    chk("stall_ready", {31'd0, pix_ready}, 1);
  endtask

  task automatic finish_idle();
    @(posedge clk); #1;
    chk("done_pulse_end", {31'd0, done}, 0);
    chk("busy_end", {31'd0, busy}, 0);
  endtask

  task automatic draw(input int x, input int y, input int w, input int h,
                      input int seed);
    cmd(x, y, w, h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        pixel(x + c, y + r, 8'(seed + r * w + c),
              (r == h - 1) && (c == w - 1));
    finish_idle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, pix_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_addr", {12'd0, mem_addr}, 0);
    chk("rst_data", {24'd0, mem_data}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 2x2 at (10,20): 12810,12811,13450,13451
    cmd(10, 20, 2, 2);
    chk("busy_write", {31'd0, busy}, 1);
    pixel(10, 20, 8'd11, 0);
    pixel(11, 20, 8'd22, 0);
    pixel(10, 21, 8'd33, 0);
    pixel(11, 21, 8'd44, 1);
    finish_idle();

    // right-edge clip
    draw(639, 0, 2, 1, 8'h50);
    // bottom-right corner
    cmd(639, 479, 1, 1);
    pixel(639, 479, 8'hAB, 1);
    finish_idle();

    // stalls plus a stray start during WRITE
    cmd(200, 100, 1, 2);
    pixel(200, 100, 8'h61, 0);
    xpos = 11'd5; ypos = 11'd5; width = 11'd3; height = 11'd3;
    start = 1'b1;
    stall_cycle();
    start = 1'b0;
    stall_cycle();
    pixel(200, 101, 8'h62, 1);
    finish_idle();

    // zero-size rectangle
    cmd(5, 5, 0, 5);
    chk("zero_done", {31'd0, done}, 1);
    chk("zero_ready", {31'd0, pix_ready}, 0);
    chk("zero_we", {31'd0, mem_we}, 0);
    finish_idle();
    chk("zero_ready_after", {31'd0, pix_ready}, 0);

    // reset after third accept of a 4x4
    cmd(100, 100, 4, 4);
    pixel(100, 100, 8'h71, 0);
    pixel(101, 100, 8'h72, 0);
    pixel(102, 100, 8'h73, 0);
    @(negedge clk); #2;
    pix_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, pix_ready}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_we", {31'd0, mem_we}, 0);
    chk("arst_addr", {12'd0, mem_addr}, 0);
    chk("arst_data", {24'd0, mem_data}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_we", {31'd0, mem_we}, 0);
      chk("post_rst_busy", {31'd0, busy}, 0);
    end
    pix_valid = 1'b0;
    draw(0, 0, 2, 2, 8'h80);

    @(negedge clk); #1;
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/framebuffer_writer.md
# framebuffer_writer

Writes a rectangular block of 8-bit palette pixels, such as a card face or a chip sprite, into the 640x480 framebuffer RAM. The rectangle origin and size come from a single start command. Pixels arrive as a row-major valid/ready stream, and the block converts them into RAM write cycles. It is the write side of the framebuffer read by the background/pixel display path, which uses the same row-major addressing: addr = y*FB_WIDTH + x.

## Interface
- FB_WIDTH, 640: framebuffer width in pixels
- FB_HEIGHT, 480: framebuffer height in pixels
- clk  in  1  system clock; the single clock for the block
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- xpos  in  11  rectangle left column; sampled with start
- ypos  in  11  rectangle top row; sampled with start
- width  in  11  rectangle width; sampled with start
- height  in  11  rectangle height; sampled with start
- pix_data  in  8  stream pixel
- pix_valid  in  1  pix_data is valid
- pix_ready  out  1  block accepts a pixel this cycle
- busy  out  1  a command is in progress
- done  out  1  one-cycle completion pulse
- mem_we  out  1  RAM write enable
- mem_addr  out  20  RAM word address
- mem_data  out  8  RAM write data

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - start=1 latches xpos, ypos, width and height.
  - Clears col and row counters.
  - Sets row_base = ypos*FB_WIDTH, computed once; there is no multiplier in the per-pixel path.
- IDLE to DONE: taken instead of WRITE if width==0 or height==0. No pixels are consumed.
- IDLE to WRITE: taken otherwise.
- WRITE:
  - pix_ready=1.
  - A pixel is accepted when pix_valid && pix_ready.
  - On each accept, the block computes x = xpos+col and y = ypos+row, both 12-bit.
  - Clipping: a write is issued only if x<FB_WIDTH and y<FB_HEIGHT. A clipped pixel is still consumed, but no write is issued.
  - Write address: row_base + xpos + col.
  - Counter stepping: col increments on each accept. When col==width-1, col clears, row increments and row_base += FB_WIDTH.
- WRITE to DONE: taken on acceptance of pixel (width-1, height-1).
- DONE: done=1 for exactly one cycle, then the FSM goes to IDLE.
- start outside IDLE is ignored; this includes the DONE cycle.
- busy=1 in WRITE and DONE.
- Reset values: state IDLE; pix_ready, busy, done, mem_we = 0; mem_addr = 0; mem_data = 0; all counters = 0.
- Reset mid-command aborts immediately. No further writes occur, and the partially drawn rectangle remains in RAM.

## Timing
- start at cycle N gives pix_ready=1 from N+1, or done=1 at N+1 for a zero-size rectangle.
- Write latency is 1 cycle. A pixel accepted at cycle k produces mem_we/mem_addr/mem_data at k+1, all registered.
- mem_we is high for exactly one cycle per unclipped accepted pixel. mem_addr and mem_data hold their last values while mem_we=0.
- The final pixel accepted at k gives its last write at k+1 and done=1 at k+1, with pix_ready=0 from k+1.
- pix_valid low stalls the block with no state change and no write. Throughput is one pixel per cycle.
- pix_ready is a function of state only and does not depend combinationally on pix_valid.

## Structure
- Package fb_pkg holds:
  - FB_WIDTH and FB_HEIGHT defaults
  - FB_ADDR_W = 20
  - the state enum typedef (IDLE/WRITE/DONE)
  - BG_COLOR = 8'h04, shared with the display path
- Sub-module fb_addr_gen holds the col/row counters, the row_base accumulator and the clip compare. Its outputs are addr, in_bounds and last.
- The FSM and output registers live in the top module.

## Test plan
- Normal 2x2 write: xpos=10, ypos=20, 2x2, pixels 11,22,33,44 streamed back-to-back. Expected writes are (12810,11), (12811,22), (13450,33), (13451,44) on consecutive cycles, with done one cycle after the last accept.
- Right-edge clip: xpos=639, ypos=0, width=2, height=1. Expected is a single write (639,pix0); pix1 is consumed with no write, then done.
- Bottom-right corner: xpos=639, ypos=479, 1x1, data 8'hAB. Expected is a write (307199,AB).
- Stalls and stray start: pix_valid toggles 1,0,0,1 during a 1x2 command. Expected is exactly 2 writes with no write in the stall cycles. A start pulse during WRITE is ignored, and the latched rectangle is unchanged.
- Zero size: width=0 with height=5. Expected is done at N+1, pix_ready never high, and no mem_we.
- Reset mid-command: rst asserted after the 3rd accept of a 4x4 command. Expected is all outputs 0 asynchronously, no further writes, and a fresh start afterwards behaving normally from origin.
